data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl.sv | 129 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with WAIT_CYCLES wait states. ACK pulses WAIT_CYCLES+1 cycles after accept.
// One access in flight at a time; REQ is ignored while BUSY, and FLUSH drops a waiting access.
module data_memory_ctrl #(
  parameter MEM_INIT_FILE           = "",
  parameter int ADDR_BIT_WIDTH      = 32,
  parameter int DATA_BIT_WIDTH      = 32,
  parameter int TRUE_ADDR_BIT_WIDTH = 11,
  parameter int IO_SEL_BIT          = 28,
  parameter int WAIT_CYCLES         = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        REQ,
  input  logic                        WE,
  input  logic [ADDR_BIT_WIDTH-1:0]   ABUS,
  input  logic [DATA_BIT_WIDTH-1:0]   WDATA,
  input  logic [DATA_BIT_WIDTH/8-1:0] BE,
  input  logic                        FLUSH,
  output logic [DATA_BIT_WIDTH-1:0]   RDATA,
  output logic                        ACK,
  output logic                        BUSY,
  output logic                        ERR
);

  localparam int DEPTH = 2 ** TRUE_ADDR_BIT_WIDTH;
  localparam int LANES = DATA_BIT_WIDTH / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]                     state;
  logic [3:0]                     cnt;
  logic [TRUE_ADDR_BIT_WIDTH-1:0] idx_q;
  logic                           mis_q;
  logic                           we_q;
  logic [DATA_BIT_WIDTH-1:0]      wdata_q;
  logic [LANES-1:0]               be_q;
  logic [DATA_BIT_WIDTH-1:0]      rdata_q;
  logic                           err_q;

  logic [DATA_BIT_WIDTH-1:0] mem [0:DEPTH-1];

  logic                           accept;
  logic                           go_resp;
  logic                           in_idle;
  logic [TRUE_ADDR_BIT_WIDTH-1:0] op_idx;
  logic                           op_mis;
  logic                           op_we;
  logic [DATA_BIT_WIDTH-1:0]      op_wdata;
  logic [LANES-1:0]               op_be;
  logic                           unused_abus;

  assign unused_abus = ^ABUS;

  assign in_idle = (state == IDLE);
  assign accept  = in_idle && REQ && !FLUSH && !ABUS[IO_SEL_BIT];
  // With zero wait states the memory op happens on the accept edge, so use the live bus.
  assign go_resp = (accept && (WAIT_CYCLES == 0)) ||
                   ((state == S_WAIT) && !FLUSH && (cnt == 4'd0));

  assign op_idx   = in_idle ? ABUS[TRUE_ADDR_BIT_WIDTH+1:2] : idx_q;
  assign op_mis   = in_idle ? (ABUS[1:0] != 2'b00) : mis_q;
  assign op_we    = in_idle ? WE : we_q;
  assign op_wdata = in_idle ? WDATA : wdata_q;
  assign op_be    = in_idle ? BE : be_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q   <= ABUS[TRUE_ADDR_BIT_WIDTH+1:2];
            mis_q   <= (ABUS[1:0] != 2'b00);
            we_q    <= WE;
            wdata_q <= WDATA;
            be_q    <= BE;
            cnt     <= CNT_INIT;
            state   <= (WAIT_CYCLES == 0) ? RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (FLUSH) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (go_resp) begin
        err_q <= op_mis;
        if (!op_we && !op_mis) rdata_q <= mem[op_idx];
      end
    end
  end

  // Memory has no reset path; RESET only suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RESET && go_resp && op_we && !op_mis) begin
      for (int i = 0; i < LANES; i++) begin
        if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

  assign RDATA = rdata_q;
  assign ACK   = (state == RESP);
  assign BUSY  = (state != IDLE);
  assign ERR   = (state == RESP) && err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: dut uses 2 wait states, dut0 uses 0 wait states; both share all inputs except REQ.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset, req, req0, we, flush;
  logic [31:0] abus, wdata;
  logic [3:0]  be;
  logic [31:0] rdata, rdata0;
  logic        ack, busy, err, ack0, busy0, err0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.WAIT_CYCLES(2)) dut (
    .CLK(clk), .RESET(reset), .REQ(req), .WE(we), .ABUS(abus), .WDATA(wdata),
    .BE(be), .FLUSH(flush), .RDATA(rdata), .ACK(ack), .BUSY(busy), .ERR(err)
  );

  data_memory_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RESET(reset), .REQ(req0), .WE(we), .ABUS(abus), .WDATA(wdata),
    .BE(be), .FLUSH(flush), .RDATA(rdata0), .ACK(ack0), .BUSY(busy0), .ERR(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic access(input bit w0, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int lat, output logic [31:0] rd,
                        output logic er);
    we = wr; abus = a; wdata = d; be = b;
    if (w0) req0 = 1'b1; else req = 1'b1;
    lat = 99; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (w0 ? ack0 : ack) begin
        lat = k;
        rd  = w0 ? rdata0 : rdata;
        er  = w0 ? err0 : err;
        break;
      end
    end
    req = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, w0 ? ack0 : ack}, 32'd0);
    chk("busy_after_ack", {31'd0, w0 ? busy0 : busy}, 32'd0);
  endtask

  task automatic wr_chk(input string tag, input bit w0, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int exp_lat, input logic exp_err);
    int lat; logic [31:0] rd; logic er;
    access(w0, 1'b1, a, d, b, lat, rd, er);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  task automatic rd_chk(input string tag, input bit w0, input logic [31:0] a,
                        input logic [31:0] exp_d, input int exp_lat, input logic exp_err);
    int lat; logic [31:0] rd; logic er;
    access(w0, 1'b0, a, 32'h0, 4'h0, lat, rd, er);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  initial begin
    int hits;
    reset = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0; flush = 1'b0;
    abus = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Known contents for the words that later tests expect to stay untouched.
    wr_chk("init80", 0, 32'h80, 32'h01234567, 4'hF, 3, 1'b0);
    wr_chk("init44", 0, 32'h44, 32'h0BADF00D, 4'hF, 3, 1'b0);

    wr_chk("wr40", 0, 32'h40, 32'hDEADBEEF, 4'hF, 3, 1'b0);
    rd_chk("rd40", 0, 32'h40, 32'hDEADBEEF, 3, 1'b0);

    wr_chk("wr40_be5", 0, 32'h40, 32'h11223344, 4'b0101, 3, 1'b0);
    rd_chk("rd40_be5", 0, 32'h40, 32'hDE22BE44, 3, 1'b0);

    wr_chk("wr40_be0", 0, 32'h40, 32'hFFFFFFFF, 4'b0000, 3, 1'b0);
    rd_chk("rd40_be0", 0, 32'h40, 32'hDE22BE44, 3, 1'b0);

    // Flush in the second wait cycle of a write.
    we = 1'b1; abus = 32'h80; wdata = 32'hCAFEF00D; be = 4'hF; req = 1'b1;
    @(negedge clk);
    chk("flush_busy_wait1", {31'd0, busy}, 32'd1);
    req = 1'b0;
    @(negedge clk);
    chk("flush_busy_wait2", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", {31'd0, busy}, 32'd0);
    chk("flush_ack_after", {31'd0, ack}, 32'd0);
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack) hits++;
    end
    chk("flush_no_ack", hits, 0);
    rd_chk("rd80_flush", 0, 32'h80, 32'h01234567, 3, 1'b0);

    // I/O-space request is never accepted.
    we = 1'b1; abus = 32'h10000040; wdata = 32'h0; be = 4'hF; req = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack || busy) hits++;
    end
    req = 1'b0;
    @(negedge clk);
    chk("io_no_busy_ack", hits, 0);
    rd_chk("rd40_io", 0, 32'h40, 32'hDE22BE44, 3, 1'b0);

    // Misaligned accesses: error ACK, RDATA held, no write.
    rd_chk("rd42_mis", 0, 32'h42, 32'hDE22BE44, 3, 1'b1);
    wr_chk("wr41_mis", 0, 32'h41, 32'h0, 4'hF, 3, 1'b1);
    rd_chk("rd40_mis", 0, 32'h40, 32'hDE22BE44, 3, 1'b0);

    // Reset during the wait phase of a write.
    we = 1'b1; abus = 32'h44; wdata = 32'h5555AAAA; be = 4'hF; req = 1'b1;
    @(negedge clk);
    chk("rstw_busy", {31'd0, busy}, 32'd1);
    req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw_ack", {31'd0, ack}, 32'd0);
    chk("rstw_busy0", {31'd0, busy}, 32'd0);
    chk("rstw_err", {31'd0, err}, 32'd0);
    chk("rstw_rdata", rdata, 32'h0);
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) hits++;
    end
    chk("rstw_no_ack", hits, 0);
    rd_chk("rd44_rst", 0, 32'h44, 32'h0BADF00D, 3, 1'b0);

    // Zero wait states.
    wr_chk("w0_wr40", 1, 32'h40, 32'h89ABCDEF, 4'hF, 1, 1'b0);
    rd_chk("w0_rd40", 1, 32'h40, 32'h89ABCDEF, 1, 1'b0);
    rd_chk("w0_rd42", 1, 32'h42, 32'h89ABCDEF, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
